// File: rtl/l15_transducer_req_queue.sv
// Core-to-L1.5 request queue with issue FSM, outstanding-request cap
// and a single-entry response skid register.
module l15_transducer_req_queue #(
  parameter int DEPTH           = 4,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        core_req_val,
  output logic        core_req_rdy,
  input  logic [4:0]  core_req_rqtype,
  input  logic [3:0]  core_req_amo_op,
  input  logic        core_req_nc,
  input  logic [2:0]  core_req_size,
  input  logic        core_req_threadid,
  input  logic [39:0] core_req_address,
  input  logic [63:0] core_req_data,
  input  logic [63:0] core_req_data_next,
  output logic        transducer_l15_val,
  output logic [4:0]  transducer_l15_rqtype,
  output logic [3:0]  transducer_l15_amo_op,
  output logic        transducer_l15_nc,
  output logic [2:0]  transducer_l15_size,
  output logic        transducer_l15_threadid,
  output logic [39:0] transducer_l15_address,
  output logic [63:0] transducer_l15_data,
  output logic [63:0] transducer_l15_data_next_entry,
  input  logic        l15_transducer_header_ack,
  input  logic        l15_transducer_ack,
  input  logic        l15_transducer_val,
  input  logic [3:0]  l15_transducer_returntype,
  input  logic        l15_transducer_threadid,
  input  logic [63:0] l15_transducer_data_0,
  input  logic [63:0] l15_transducer_data_1,
  output logic        transducer_l15_req_ack,
  output logic        core_resp_val,
  input  logic        core_resp_rdy,
  output logic [3:0]  core_resp_returntype,
  output logic        core_resp_threadid,
  output logic [63:0] core_resp_data_0,
  output logic [63:0] core_resp_data_1,
  output logic [3:0]  outstanding_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic [4:0]  rqtype;
    logic [3:0]  amo_op;
    logic        nc;
    logic [2:0]  size;
    logic        threadid;
    logic [39:0] address;
    logic [63:0] data;
    logic [63:0] data_next;
  } entry_t;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_ACK
  } state_t;

  entry_t          mem [DEPTH];
  entry_t          head;
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [CW-1:0]   count;
  logic            push;
  logic            pop;
  logic            issue;
  logic            counted;
  logic            skid_full;
  state_t          state;
  state_t          state_next;

  assign core_req_rdy = (count != CW'(DEPTH));
  assign push = core_req_val & core_req_rdy;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= '{
        rqtype:    core_req_rqtype,
        amo_op:    core_req_amo_op,
        nc:        core_req_nc,
        size:      core_req_size,
        threadid:  core_req_threadid,
        address:   core_req_address,
        data:      core_req_data,
        data_next: core_req_data_next
      };
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    pop        = 1'b0;
    issue      = 1'b0;
    case (state)
      IDLE: begin
        if (count != '0 &&
            outstanding_cnt < 4'(MAX_OUTSTANDING)) begin
          state_next = ISSUE;
          issue      = 1'b1;
        end
      end
      ISSUE: begin
        if (l15_transducer_header_ack) begin
          if (l15_transducer_ack) begin
            pop        = 1'b1;
            state_next = IDLE;
          end else begin
            state_next = WAIT_ACK;
          end
        end
      end
      WAIT_ACK: begin
        if (l15_transducer_ack) begin
          pop        = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Fields read as zero while idle so nothing stale leaks out.
  assign head = (state == IDLE) ? '0 : mem[rd_ptr];

  assign transducer_l15_val             = (state == ISSUE);
  assign transducer_l15_rqtype          = head.rqtype;
  assign transducer_l15_amo_op          = head.amo_op;
  assign transducer_l15_nc              = head.nc;
  assign transducer_l15_size            = head.size;
  assign transducer_l15_threadid        = head.threadid;
  assign transducer_l15_address         = head.address;
  assign transducer_l15_data            = head.data;
  assign transducer_l15_data_next_entry = head.data_next;

  assign transducer_l15_req_ack = l15_transducer_val & ~skid_full;
  assign counted = transducer_l15_req_ack &
                   (l15_transducer_returntype != 4'b0011) &
                   (l15_transducer_returntype != 4'b0111);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      outstanding_cnt <= '0;
    end else if (issue && !counted) begin
      outstanding_cnt <= outstanding_cnt + 4'd1;
    end else if (!issue && counted && outstanding_cnt != '0) begin
      outstanding_cnt <= outstanding_cnt - 4'd1;
    end
  end

  a_cnt_underflow: assert property (
    @(posedge clk) disable iff (rst)
    !(counted && !issue && outstanding_cnt == 4'd0));

  assign core_resp_val = skid_full;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      skid_full            <= 1'b0;
      core_resp_returntype <= '0;
      core_resp_threadid   <= 1'b0;
      core_resp_data_0     <= '0;
      core_resp_data_1     <= '0;
    end else if (transducer_l15_req_ack) begin
      skid_full            <= 1'b1;
      core_resp_returntype <= l15_transducer_returntype;
      core_resp_threadid   <= l15_transducer_threadid;
      core_resp_data_0     <= l15_transducer_data_0;
      core_resp_data_1     <= l15_transducer_data_1;
    end else if (core_resp_rdy) begin
      skid_full <= 1'b0;
    end
  end

endmodule

// File: doc/l15_transducer_req_queue.md
Name: l15_transducer_req_queue

Overview:
- Core-side transducer stage that feeds the L1.5 request interface and consumes its response interface.
- Buffers core requests in a FIFO and issues them one at a time with the L1.5 header_ack/ack handshake.
- Caps outstanding requests awaiting a response, and holds one L1.5 response in a skid register until the core accepts it.

Parameters:
DEPTH, 4, request FIFO entries (power of 2, >=2)
MAX_OUTSTANDING, 2, max issued requests without a counted response (1..15)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
core_req_val  in  1  core request valid
core_req_rdy  out  1  FIFO can accept (not full)
core_req_rqtype  in  5  request type
core_req_amo_op  in  4  atomic op
core_req_nc  in  1  non-cacheable
core_req_size  in  3  access size
core_req_threadid  in  1  thread id
core_req_address  in  40  physical address
core_req_data  in  64  store/swap data
core_req_data_next  in  64  second data word (CAS)
transducer_l15_val  out  1  request valid to L1.5
transducer_l15_rqtype/amo_op/nc/size/threadid/address/data/data_next_entry  out  5/4/1/3/1/40/64/64  head-entry fields
l15_transducer_header_ack  in  1  L1.5 accepted header
l15_transducer_ack  in  1  L1.5 consumed request
l15_transducer_val  in  1  L1.5 response valid
l15_transducer_returntype  in  4  response type
l15_transducer_threadid  in  1  response thread
l15_transducer_data_0  in  64  response data word 0
l15_transducer_data_1  in  64  response data word 1
transducer_l15_req_ack  out  1  response accepted
core_resp_val  out  1  response to core valid
core_resp_rdy  in  1  core accepts response
core_resp_returntype  out  4  captured returntype
core_resp_threadid  out  1  captured thread
core_resp_data_0  out  64  captured data 0
core_resp_data_1  out  64  captured data 1
outstanding_cnt  out  4  issued-but-unanswered count

Behaviour:
- Reset: FIFO empty and pointers 0. FSM enters IDLE. Counter 0. Skid register empty.
- Reset values: transducer_l15_val=0, core_resp_val=0, outstanding_cnt=0, core_req_rdy=1, all data/field outputs 0.
- Reset asserted mid-operation discards queued entries, the in-flight request and the held response, with no further acks.
- FIFO push: core_req_val & core_req_rdy pushes the entry. core_req_rdy=0 when count==DEPTH.
- FIFO push when full: no push, no change in state.
- Simultaneous push and pop when full: the pop frees the slot in the same cycle, but core_req_rdy is computed from the registered count, so the push is not taken that cycle.
- Pointers wrap modulo DEPTH.
- Issue FSM states: IDLE, ISSUE, WAIT_ACK.
- IDLE -> ISSUE when FIFO is non-empty and outstanding_cnt < MAX_OUTSTANDING. outstanding_cnt increments on this transition.
- ISSUE: transducer_l15_val=1. Fields are driven from the head entry and stay stable until the pop.
  - On header_ack & ack in the same cycle: pop, go to IDLE.
  - On header_ack alone: go to WAIT_ACK; val is low from the next cycle.
- WAIT_ACK: val=0, fields held. On ack: pop, go to IDLE.
- ack while in IDLE is ignored.
- Minimum spacing between issues: 1 idle cycle. val never asserts in the cycle after a pop.
- Response path: transducer_l15_req_ack = l15_transducer_val & ~skid_full (combinational).
  - On req_ack, capture returntype, threadid, data_0 and data_1; core_resp_val=1 from the next cycle.
  - Skid empties on core_resp_val & core_resp_rdy.
  - When the skid empties and a new response arrives in the same cycle, req_ack=0 that cycle (the skid-full check uses registered state).
- Counted responses: accepted responses with returntype != 4'b0011 (invalidation/evict) and != 4'b0111 (interrupt).
- outstanding_cnt: +1 on issue, -1 on a counted response.
  - Simultaneous increment and decrement: unchanged.
  - Decrement at 0: saturates at 0 and flags an assertion error in simulation.
  - Never exceeds MAX_OUTSTANDING.

Test Plan:
1. Reset, push one load (rqtype 5'b00000, addr 40'h80_0000_0040). Required: val rises 2 cycles after the push, is held until header_ack, then falls; pop on ack; outstanding_cnt=1.
2. Push 4 entries with DEPTH=4. Required: core_req_rdy=0 after the 4th push; a 5th core_req_val is not accepted; rdy returns to 1 the cycle after the first pop.
3. MAX_OUTSTANDING=2, 3 queued requests, no responses. Required: exactly 2 issued and the 3rd is held in IDLE; one response with returntype 4'b0000 lets the 3rd issue and outstanding_cnt returns to 2.
4. Response returntype 4'b0011 arrives while outstanding_cnt=1. Required: req_ack=1 and core_resp_val=1 with the data; outstanding_cnt stays at 1.
5. Hold core_resp_rdy=0 and send 2 responses. Required: 1st is acked; 2nd sees req_ack=0 until the cycle after core_resp_rdy=1 drains the skid; data_0 values are delivered in order.
6. Assert rst while in WAIT_ACK with 3 entries queued. Required: val=0, FIFO empty, outstanding_cnt=0 and core_resp_val=0 immediately (asynchronous); normal operation after deassert.
